// File: rtl/mult_sequencer.sv
// Control FSM for the N-bit signed shift-add multiplier datapath: clear/load,
// N add/shift rounds (the last one subtracts), then hold DONE until Run drops.
module mult_sequencer #(
  parameter int N             = 8,
  parameter bit SKIP_ZERO_ADD = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Clr_Ld,
  input  logic                 Run,
  input  logic                 M,
  output logic                 CLXA,
  output logic                 Ld_B,
  output logic                 Add,
  output logic                 Subtract,
  output logic                 Shift,
  output logic                 Busy,
  output logic                 Done,
  output logic [$clog2(N)-1:0] Round
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          add_en;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (Run && !Clr_Ld) state <= CLRA;
        CLRA: begin
          cnt   <= '0;
          state <= ADD;
        end
        ADD:   state <= SHIFT;
        SHIFT: begin
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        // Waiting for Run to drop prevents a held button from retriggering.
        DONE:  if (!Run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The add enable is suppressed on zero multiplier bits only when skipping is enabled.
  assign add_en = SKIP_ZERO_ADD ? M : 1'b1;

  always_comb begin
    CLXA     = 1'b0;
    Ld_B     = 1'b0;
    Add      = 1'b0;
    Subtract = 1'b0;
    Shift    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Round    = '0;
    case (state)
      IDLE: begin
        // Gated by Reset_n so the button cannot drive the datapath while in reset.
        CLXA = Clr_Ld && Reset_n;
        Ld_B = Clr_Ld && Reset_n;
      end
      CLRA: begin
        CLXA = 1'b1;
        Busy = 1'b1;
      end
      ADD: begin
        Add      = add_en;
        Subtract = add_en && (cnt == LAST);
        Busy     = 1'b1;
        Round    = cnt;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        Round = cnt;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomised and directed bench for mult_sequencer; two instances (add skipping
// off/on) share stimulus and are checked against a cycles-since-start timeline model.
module tb_mult_sequencer;
  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_ld = 1'b0;
  logic run = 1'b0;
  logic m = 1'b0;

  logic clxa0, ld_b0, add0, sub0, shift0, busy0, done0;
  logic clxa1, ld_b1, add1, sub1, shift1, busy1, done1;
  logic [CW-1:0] round0, round1;

  int p = 0;      // 0 idle, 1..2N+1 cycles since start, 2N+2 done
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_sequencer #(.N(N), .SKIP_ZERO_ADD(1'b0)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .Clr_Ld(clr_ld), .Run(run), .M(m),
    .CLXA(clxa0), .Ld_B(ld_b0), .Add(add0), .Subtract(sub0), .Shift(shift0),
    .Busy(busy0), .Done(done0), .Round(round0)
  );

  mult_sequencer #(.N(N), .SKIP_ZERO_ADD(1'b1)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Clr_Ld(clr_ld), .Run(run), .M(m),
    .CLXA(clxa1), .Ld_B(ld_b1), .Add(add1), .Subtract(sub1), .Shift(shift1),
    .Busy(busy1), .Done(done1), .Round(round1)
  );

  wire [CW+6:0] obs0 = {clxa0, ld_b0, add0, sub0, shift0, busy0, done0, round0};
  wire [CW+6:0] obs1 = {clxa1, ld_b1, add1, sub1, shift1, busy1, done1, round1};

  // Expected outputs from the position in the timeline: CLRA at 1, ADD round k at
  // 2+2k, SHIFT round k at 3+2k, DONE from 2N+2.
  function automatic logic [CW+6:0] expected(input bit skip);
    logic [CW+6:0] e;
    int k;
    logic a;
    e = '0;
    if (!rst_n) return e;
    if (p == 0) begin
      e[CW+6] = clr_ld;
      e[CW+5] = clr_ld;
    end else if (p == 1) begin
      e[CW+6] = 1'b1;
      e[CW+1] = 1'b1;
    end else if (p <= 2*N+1) begin
      e[CW+1] = 1'b1;
      if (p % 2 == 0) begin
        k = (p - 2) / 2;
        a = !skip || m;
        e[CW+4] = a;
        e[CW+3] = a && (k == N-1);
      end else begin
        k = (p - 3) / 2;
        e[CW+2] = 1'b1;
      end
      e[CW-1:0] = k[CW-1:0];
    end else begin
      e[CW] = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [CW+6:0] got, input logic [CW+6:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b (phase %0d)", tag, $time, got, exp, p);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic mm);
    @(negedge clk);
    run = r;
    clr_ld = c;
    m = mm;
    #1;
    $display("[TB] t=%0t phase=%0d run=%b clr=%b m=%b out0=%b out1=%b",
             $time, p, run, clr_ld, m, obs0, obs1);
    check("noskip", obs0, expected(1'b0));
    check("skip", obs1, expected(1'b1));
    @(posedge clk);
    if (p == 0) begin
      if (run && !clr_ld) p = 1;
    end else if (p <= 2*N+1) begin
      p++;
    end else if (!run) begin
      p = 0;
    end
  endtask

  initial begin
    // Reset state: outputs quiet even with the button pressed.
    clr_ld = 1'b1;
    #1;
    check("reset0", obs0, '0);
    check("reset1", obs1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_ld = 1'b0;

    // Clr_Ld with Run for 3 cycles: load only, no start.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Run pulse, M=1 every round, through DONE and back to IDLE.
    step(1'b1, 1'b0, 1'b1);
    repeat (2*N + 2) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Skip-zero pattern: M=1 only during ADD of the last round.
    step(1'b1, 1'b0, 1'b0);
    repeat (2*N + 2) step(1'b0, 1'b0, (p == 2*N));
    step(1'b0, 1'b0, 1'b0);

    // Run held 30 cycles, then dropped, then reasserted and held.
    repeat (30) step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (25) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Clr_Ld toggling throughout a multiply.
    step(1'b1, 1'b0, 1'b1);
    repeat (2*N + 3) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Reset during SHIFT of round 3, then a fresh full sequence.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && p != 9; i++) step(1'b0, 1'b0, 1'b1);
    check("reached_shift3", {{(CW+6){1'b0}}, 1'b1}, {{(CW+6){1'b0}}, (p == 9)});
    @(negedge clk);
    rst_n = 1'b0;
    clr_ld = 1'b1;
    run = 1'b1;
    p = 0;
    #1;
    check("midreset0", obs0, '0);
    check("midreset1", obs1, '0);
    @(posedge clk);
    #1;
    check("heldreset0", obs0, '0);
    check("heldreset1", obs1, '0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_ld = 1'b0;
    run = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    repeat (2*N + 3) step(1'b0, 1'b0, $urandom_range(0, 1));

    // Random traffic with a sticky Run level.
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 4) == 0) ? !run : run;
      step(r, ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
